// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU operation codes, operand
// select encodings and default datapath widths.
package ex_operand_stage_pkg;

  localparam int unsigned DefXlen = 32;
  localparam int unsigned DefRegw = 5;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSll  = 4'b0001,
    AluSlt  = 4'b0010,
    AluSltu = 4'b0011,
    AluXor  = 4'b0100,
    AluSrl  = 4'b0101,
    AluOr   = 4'b0110,
    AluAnd  = 4'b0111,
    AluSub  = 4'b1000,
    AluSra  = 4'b1101
  } alu_op_e;

  typedef enum logic {
    Op1Rs1 = 1'b0,
    Op1Pc  = 1'b1
  } op1_sel_e;

  typedef enum logic {
    Op2Rs2 = 1'b0,
    Op2Imm = 1'b1
  } op2_sel_e;

endpackage

// File: rtl/ex_operand_stage_forward_unit.sv
// Selects the freshest value of one source register: MEM result, then WB
// result, then the value read from the register file. x0 is never forwarded.
module ex_operand_stage_forward_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic [REGW-1:0] rs_i,
  input  logic [XLEN-1:0] reg_val_i,
  input  logic [REGW-1:0] mem_rd_i,
  input  logic            mem_reg_write_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic [REGW-1:0] wb_rd_i,
  input  logic            wb_reg_write_i,
  input  logic [XLEN-1:0] wb_result_i,
  output logic [XLEN-1:0] fwd_o
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs_i);
    wb_hit  = wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs_i);
    fwd_o   = reg_val_i;
    if (mem_hit) begin
      fwd_o = mem_result_i;
    end else if (wb_hit) begin
      fwd_o = wb_result_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use stall
// detection, global hold and branch flush.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN = DefXlen,
  parameter int unsigned REGW = DefRegw
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_reg1,
  input  logic [XLEN-1:0] id_reg2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [3:0]      id_alu_ctrl,
  input  logic            id_op1_sel,
  input  logic            id_op2_sel,
  input  logic            id_is_load,
  input  logic            id_reg_write,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] Operand1,
  output logic [XLEN-1:0] Operand2,
  output logic [3:0]      AluContrl,
  output logic            ex_valid,
  output logic            ex_is_load,
  output logic            ex_reg_write,
  output logic [REGW-1:0] ex_rd,
  output logic [XLEN-1:0] ex_store_data,
  output logic            stall_id
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] reg1;
    logic [XLEN-1:0] reg2;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic            use_rs1;
    logic            use_rs2;
    logic [3:0]      alu_ctrl;
    logic            op1_sel;
    logic            op2_sel;
    logic            is_load;
    logic            reg_write;
  } ex_regs_t;

  localparam ex_regs_t BubbleRegs = '{alu_ctrl: AluAdd, default: '0};

  ex_regs_t ex_q, ex_d, id_regs;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic rs1_dep, rs2_dep;

  always_comb begin
    id_regs = '{
      valid:     id_valid,
      pc:        id_pc,
      reg1:      id_reg1,
      reg2:      id_reg2,
      imm:       id_imm,
      rs1:       id_rs1,
      rs2:       id_rs2,
      rd:        id_rd,
      use_rs1:   id_use_rs1,
      use_rs2:   id_use_rs2,
      alu_ctrl:  id_alu_ctrl,
      op1_sel:   id_op1_sel,
      op2_sel:   id_op2_sel,
      is_load:   id_is_load,
      reg_write: id_reg_write
    };
  end

  // A load in EX cannot supply its data until WB, so a dependent in ID waits.
  always_comb begin
    rs1_dep  = id_use_rs1 && (id_rs1 == ex_q.rd);
    rs2_dep  = id_use_rs2 && (id_rs2 == ex_q.rd);
    stall_id = ex_q.valid && ex_q.is_load && (ex_q.rd != '0) && (rs1_dep || rs2_dep) &&
               id_valid && !flush;
  end

  always_comb begin
    ex_d = ex_q;
    if (!hold) begin
      if (flush || stall_id) begin
        ex_d = BubbleRegs;
      end else begin
        ex_d = id_regs;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= BubbleRegs;
    end else begin
      ex_q <= ex_d;
    end
  end

  ex_operand_stage_forward_unit #(
    .XLEN(XLEN),
    .REGW(REGW)
  ) u_fwd_rs1 (
    .rs_i           (ex_q.rs1),
    .reg_val_i      (ex_q.reg1),
    .mem_rd_i       (mem_rd),
    .mem_reg_write_i(mem_reg_write),
    .mem_result_i   (mem_result),
    .wb_rd_i        (wb_rd),
    .wb_reg_write_i (wb_reg_write),
    .wb_result_i    (wb_result),
    .fwd_o          (fwd_rs1)
  );

  ex_operand_stage_forward_unit #(
    .XLEN(XLEN),
    .REGW(REGW)
  ) u_fwd_rs2 (
    .rs_i           (ex_q.rs2),
    .reg_val_i      (ex_q.reg2),
    .mem_rd_i       (mem_rd),
    .mem_reg_write_i(mem_reg_write),
    .mem_result_i   (mem_result),
    .wb_rd_i        (wb_rd),
    .wb_reg_write_i (wb_reg_write),
    .wb_result_i    (wb_result),
    .fwd_o          (fwd_rs2)
  );

  always_comb begin
    Operand1      = (ex_q.op1_sel == Op1Pc) ? ex_q.pc : fwd_rs1;
    Operand2      = (ex_q.op2_sel == Op2Imm) ? ex_q.imm : fwd_rs2;
    ex_store_data = fwd_rs2;
    AluContrl     = ex_q.alu_ctrl;
    ex_valid      = ex_q.valid;
    ex_is_load    = ex_q.is_load;
    ex_reg_write  = ex_q.reg_write;
    ex_rd         = ex_q.rd;
  end

endmodule
